// File: rtl/regfile_wr_sched_pkg.sv
// Shared constants for the register-file write-port scheduler: fixed register
// numbers and the two-state controller encoding.
package regfile_wr_sched_pkg;

  localparam logic [4:0] REG_LINK        = 5'd31;
  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam logic [4:0] REG_FIRST_CLEAR = 5'd1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      idx
);

  logic       found;
  logic [3:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate position ptr+k folded back into 0..NREQ-1.
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (cand == 4'(i))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Shares the register file's single write port between NREQ requesters and
// zero-fills registers 1..31 after reset, since the file itself has no reset.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]  req_link,
  output logic [AW-1:0]    rf_rw,
  output logic [DW-1:0]    rf_busw,
  output logic             rf_wren,
  output logic             rf_jal,
  output logic [2:0]       grant_id,
  output logic             init_busy
);

  // Handshake: a requester's write is taken on a rising edge where both
  // req_valid[i] and req_ready[i] are high; ready is one-hot, only in ARB, and
  // never gates valid. Requesters hold valid/addr/data/link until ready.

  logic [0:0]      state;
  logic [AW-1:0]   clr_cnt;
  logic [2:0]      rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [2:0]      win;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_link;
  logic [AW-1:0]   res_addr;
  logic            accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_link = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
        sel_link = req_link[i];
      end
    end
  end

  assign res_addr  = sel_link ? AW'(REG_LINK) : sel_addr;
  assign accept    = (state == ST_ARB) && (|req_valid);
  assign req_ready = (state == ST_ARB) ? gnt : '0;
  // init_busy is the controller state seen from outside: high exactly in CLEAR.
  assign init_busy = (state == ST_CLEAR);
  // Link writes are already resolved to register 31 here.
  assign rf_jal    = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
      clr_cnt  <= AW'(REG_FIRST_CLEAR);
      rr_ptr   <= 3'd0;
      rf_wren  <= 1'b0;
      rf_rw    <= '0;
      rf_busw  <= '0;
      grant_id <= 3'd0;
    end else if (state == ST_CLEAR) begin
      rf_wren <= 1'b1;
      rf_rw   <= clr_cnt;
      rf_busw <= '0;
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(REG_LINK)) begin
        state <= ST_ARB;
      end
    end else if (accept) begin
      // Writes to register 0 are acknowledged but never reach the file.
      rf_wren  <= (res_addr != AW'(REG_ZERO));
      rf_rw    <= res_addr;
      rf_busw  <= sel_data;
      grant_id <= win;
      rr_ptr   <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
    end else begin
      rf_wren <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomized bench for regfile_wr_sched: a driver with a spec-level model
// predicts grants and pushes expected register-file writes; a monitor pops them.
module tb_regfile_wr_sched;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_link;
  logic [AW-1:0]     rf_rw;
  logic [DW-1:0]     rf_busw;
  logic              rf_wren;
  logic              rf_jal;
  logic [2:0]        grant_id;
  logic              init_busy;

  regfile_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_link  (req_link),
    .rf_rw     (rf_rw),
    .rf_busw   (rf_busw),
    .rf_wren   (rf_wren),
    .rf_jal    (rf_jal),
    .grant_id  (grant_id),
    .init_busy (init_busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [3+AW+DW-1:0] exp_q[$];   // {grant, addr, data}
  logic [DW-1:0]      rf_mem[32];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int m_clear;   // next register to be zero-filled; >31 means init done
  int m_ptr;
  int m_grant;
  logic [NREQ-1:0] rdy_seen;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1;
    m_ptr   = 0;
    m_grant = 0;
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input logic v, input int addr,
                         input logic [DW-1:0] data, input logic link);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = AW'(addr);
    req_data[i*DW +: DW] = data;
    req_link[i]          = link;
  endtask

  // Called just after a falling edge with inputs applied; predicts what the
  // coming rising edge does, then waits for the next falling edge.
  task automatic step();
    int w;
    int j;
    int ra;
    logic [NREQ-1:0] exp_rdy;
    #1;
    rdy_seen = req_ready;
    chk("init_busy", {63'd0, init_busy}, {63'd0, (m_clear <= 31)});
    if (m_clear <= 31) begin
      chk("ready_in_clear", {61'd0, req_ready}, 64'd0);
      exp_q.push_back({3'(m_grant), AW'(m_clear), {DW{1'b0}}});
      m_clear++;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[j]) w = j;
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
      if (w >= 0) begin
        ra      = req_link[w] ? 31 : int'(req_addr[w*AW +: AW]);
        m_grant = w;
        m_ptr   = (w + 1) % NREQ;
        if (ra != 0)
          exp_q.push_back({3'(w), AW'(ra), req_data[w*DW +: DW]});
      end
    end
    @(negedge clk);
  endtask

  // ---------------- register file model and monitor ----------------
  always @(posedge clk) begin
    if (rf_wren) rf_mem[rf_rw] <= rf_busw;
  end

  always @(negedge clk) begin
    logic [3+AW+DW-1:0] e;
    if (!rst && rf_wren) begin
      chk("rf_jal", {63'd0, rf_jal}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_rw, rf_busw}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rf_rw", {59'd0, rf_rw}, {59'd0, e[DW +: AW]});
        chk("rf_busw", {32'd0, rf_busw}, {32'd0, e[DW-1:0]});
        chk("grant_id", {61'd0, grant_id}, {61'd0, e[DW+AW +: 3]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_link  = '0;
    rdy_seen  = '0;
    model_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 10, DW'(i), 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_wren", {63'd0, rf_wren}, 64'd0);
    chk("rst_rw", {59'd0, rf_rw}, 64'd0);
    chk("rst_busw", {32'd0, rf_busw}, 64'd0);
    chk("rst_grant", {61'd0, grant_id}, 64'd0);
    chk("rst_init_busy", {63'd0, init_busy}, 64'd1);
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    rst = 1'b0;

    // zero-fill with all requesters pending
    for (int c = 0; c < 31; c++) step();

    // rotation: grants 0,1,2,0 to registers 2,3,4,2
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 2, 32'h100 + DW'(i), 1'b0);
    for (int c = 0; c < 4; c++) step();

    // link write from requester 1
    req_valid = '0;
    set_req(1, 1'b1, 7, 32'h0040_0008, 1'b1);
    step();
    req_valid = '0;
    step();

    // write to register 0 is acknowledged and dropped
    set_req(0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);
    step();
    chk("zero_wren", {63'd0, rf_wren}, 64'd0);
    req_valid = '0;
    step();

    // back-to-back writes to register 5, last one wins
    set_req(0, 1'b1, 5, 32'h11, 1'b0);
    step();
    req_valid = '0;
    set_req(1, 1'b1, 5, 32'h22, 1'b0);
    step();
    req_valid = '0;
    step();
    step();
    chk("reg5_readback", {32'd0, rf_mem[5]}, 64'h22);

    // random traffic honouring the hold-until-ready rule
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !rdy_seen[i] && $urandom_range(0, 7) != 0)) begin
          set_req(i, $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
                  $urandom, $urandom_range(0, 5) == 0);
        end
      end
      step();
    end

    // asynchronous reset while an accepted write is on the rf_* outputs
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 20, 32'hA0 + DW'(i), 1'b0);
    step();
    chk("pre_rst_wren", {63'd0, rf_wren}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wren", {63'd0, rf_wren}, 64'd0);
    chk("async_rst_rw", {59'd0, rf_rw}, 64'd0);
    chk("async_rst_init_busy", {63'd0, init_busy}, 64'd1);
    chk("async_rst_ready", {61'd0, req_ready}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 31 + 4; c++) step();

    req_valid = '0;
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
